// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, error detection and an output FIFO.
// Frames are timed by an external oversampling tick strobe; everything runs on sysclk.
module uart_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          rxd,
    input  logic                          rx_ready,
    output logic                          rx_valid,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          break_det,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [3:0]  TC_HALF = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  TC_FULL = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  BC_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  BC_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0] DEPTH   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                 rxd_m, rxd_s;
    state_t               state;
    logic [3:0]           tc, bc;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit, perr, ferr, hold;
    logic                 wr_req;
    logic [EW-1:0]        wr_entry;
    logic                 stop_low;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame error accumulates across all stop samples, including the current one.
    assign stop_low = ferr | ~rxd_s;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= IDLE;
            tc        <= '0;
            bc        <= '0;
            shreg     <= '0;
            pbit      <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            hold      <= 1'b0;
            wr_req    <= 1'b0;
            wr_entry  <= '0;
            break_det <= 1'b0;
        end else begin
            wr_req    <= 1'b0;
            break_det <= 1'b0;
            case (state)
                IDLE: begin
                    tc <= '0;
                    // After a break the line must return high before a new start is armed.
                    if (hold) begin
                        if (rxd_s) hold <= 1'b0;
                    end else if (tick && !rxd_s) begin
                        state <= START;
                    end
                end
                START: if (tick) begin
                    if (tc == TC_HALF) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            tc    <= '0;
                            bc    <= '0;
                            pbit  <= 1'b0;
                            perr  <= 1'b0;
                            ferr  <= 1'b0;
                            state <= DATA;
                        end
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                DATA: if (tick) begin
                    if (tc == TC_FULL) begin
                        tc    <= '0;
                        shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bc == BC_DATA) begin
                            bc    <= '0;
                            state <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bc <= bc + 4'd1;
                        end
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                PARITY: if (tick) begin
                    if (tc == TC_FULL) begin
                        tc    <= '0;
                        pbit  <= rxd_s;
                        perr  <= ((^shreg) ^ rxd_s) != (PARITY_MODE == 2);
                        state <= STOP;
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                STOP: if (tick) begin
                    if (tc == TC_FULL) begin
                        tc   <= '0;
                        ferr <= stop_low;
                        if (bc == BC_STOP) begin
                            bc        <= '0;
                            wr_req    <= 1'b1;
                            wr_entry  <= {stop_low, perr, shreg};
                            break_det <= stop_low && (shreg == '0) && !pbit;
                            hold      <= stop_low && (shreg == '0) && !pbit;
                            state     <= IDLE;
                        end else begin
                            bc <= bc + 4'd1;
                        end
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Output handshake: the head entry transfers on any cycle where rx_valid && rx_ready;
    // rx_valid stays high and the head stays stable until that transfer.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_pop, do_wr, full;
    logic [EW-1:0] head;

    assign full   = (count == DEPTH);
    assign do_pop = rx_valid && rx_ready;
    assign do_wr  = wr_req && (!full || do_pop);

    always_ff @(posedge sysclk) begin
        if (do_wr) mem[wptr] <= wr_entry;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_wr)  wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_req && !do_wr)   overrun <= 1'b1;
            else if (overrun_clr)   overrun <= 1'b0;
        end
    end

    assign rx_valid      = (count != '0);
    assign fifo_count    = count;
    assign head          = rx_valid ? mem[rptr] : '0;
    assign rx_data       = head[DATA_BITS-1:0];
    assign rx_parity_err = head[DATA_BITS];
    assign rx_frame_err  = head[DATA_BITS+1];

endmodule
